// File: rtl/memcode_arbiter.sv
// Arbitrates one synchronous code ROM between NUM_REQ PRN memory-code requesters
// (round-robin) and a host debug port (priority, with a bounded streak).
module memcode_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int HOST_MAX = 4,
  localparam int LG_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic [NUM_REQ-1:0]      req_rd,
  input  logic [NUM_REQ*14-1:0]   req_addr,
  output logic [NUM_REQ-1:0]      req_read_valid,
  output logic [31:0]             memcode_data,
  input  logic                    host_rd,
  input  logic [13:0]             host_addr,
  output logic                    host_ready,
  output logic [31:0]             host_rdata,
  output logic                    host_rdata_valid,
  output logic                    rom_rd,
  output logic [13:0]             rom_addr,
  input  logic [31:0]             rom_data,
  output logic [LG_W-1:0]         o_dbg_last_grant,
  output logic [2:0]              o_dbg_host_streak
);

  // Handshake: a requester holds req_rd (or host_rd) high with a stable address
  // until it sees req_read_valid (or host_ready) in the same cycle; that cycle is
  // the ROM access, and the data appears on memcode_data for the whole next cycle.

  localparam logic [2:0]      HMAX       = 3'(HOST_MAX);
  localparam logic [LG_W-1:0] LAST_RESET = LG_W'(NUM_REQ - 1);

  logic [LG_W-1:0]    r_last_grant;
  logic [2:0]         r_host_streak;
  logic               r_host_inflight;
  logic [31:0]        r_host_rdata;
  logic               r_host_rdata_valid;

  logic               w_any_req;
  logic               w_host_block;
  logic               w_host_gnt;
  logic               w_rr_found;
  logic [LG_W-1:0]    w_rr_idx;
  logic [LG_W-1:0]    w_cand;
  logic               w_req_win;
  logic [NUM_REQ-1:0] w_req_gnt;
  logic [13:0]        w_rom_addr;
  logic [2:0]         w_streak_nxt;

  assign w_any_req    = |req_rd;
  assign w_host_block = (r_host_streak == HMAX) && w_any_req;
  assign w_host_gnt   = host_rd && !w_host_block;

  // Cyclic search starting just above the last requester that was served.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_cand     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = LG_W'((int'(r_last_grant) + i) % NUM_REQ);
      if (!w_rr_found && req_rd[w_cand]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_cand;
      end
    end
  end

  assign w_req_win = w_rr_found && !w_host_gnt;

  always_comb begin
    w_req_gnt = '0;
    if (w_req_win) begin
      w_req_gnt[w_rr_idx] = 1'b1;
    end
  end

  always_comb begin
    w_rom_addr = 14'd0;
    if (w_host_gnt) begin
      w_rom_addr = host_addr;
    end else if (w_req_win) begin
      w_rom_addr = req_addr[int'(w_rr_idx)*14 +: 14];
    end
  end

  // The streak only counts host wins that actually held off a requester.
  always_comb begin
    w_streak_nxt = r_host_streak;
    if (!w_any_req || w_req_win) begin
      w_streak_nxt = 3'd0;
    end else if (w_host_gnt && (r_host_streak != HMAX)) begin
      w_streak_nxt = r_host_streak + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_last_grant       <= LAST_RESET;
      r_host_streak      <= 3'd0;
      r_host_inflight    <= 1'b0;
      r_host_rdata       <= 32'd0;
      r_host_rdata_valid <= 1'b0;
    end else begin
      r_host_streak      <= w_streak_nxt;
      r_host_inflight    <= w_host_gnt;
      r_host_rdata_valid <= r_host_inflight;
      if (w_req_win) begin
        r_last_grant <= w_rr_idx;
      end
      // ROM output for a host grant at T is present during T+1.
      if (r_host_inflight) begin
        r_host_rdata <= rom_data;
      end
    end
  end

  assign req_read_valid    = w_req_gnt;
  assign host_ready        = w_host_gnt;
  assign rom_rd            = w_host_gnt || w_req_win;
  assign rom_addr          = w_rom_addr;
  assign memcode_data      = rom_data;
  assign host_rdata        = r_host_rdata;
  assign host_rdata_valid  = r_host_rdata_valid;
  assign o_dbg_last_grant  = r_last_grant;
  assign o_dbg_host_streak = r_host_streak;

endmodule

// File: tb/tb_memcode_arbiter.sv
// Self-checking bench for memcode_arbiter: scenario tasks plus a data scoreboard
// that checks memcode_data one cycle after each grant.
module tb_memcode_arbiter;

  localparam int NR = 4;
  localparam int HM = 4;

  logic          clk = 1'b0;
  logic          rst_b;
  logic [NR-1:0] req_rd;
  logic [NR*14-1:0] req_addr;
  logic [NR-1:0] req_read_valid;
  logic [31:0]   memcode_data;
  logic          host_rd;
  logic [13:0]   host_addr;
  logic          host_ready;
  logic [31:0]   host_rdata;
  logic          host_rdata_valid;
  logic          rom_rd;
  logic [13:0]   rom_addr;
  logic [31:0]   rom_data = 32'd0;
  logic [1:0]    dbg_last;
  logic [2:0]    dbg_streak;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int pend_cnt = 0;

  memcode_arbiter #(.NUM_REQ(NR), .HOST_MAX(HM)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_rd(req_rd), .req_addr(req_addr), .req_read_valid(req_read_valid),
    .memcode_data(memcode_data),
    .host_rd(host_rd), .host_addr(host_addr), .host_ready(host_ready),
    .host_rdata(host_rdata), .host_rdata_valid(host_rdata_valid),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .o_dbg_last_grant(dbg_last), .o_dbg_host_streak(dbg_streak)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [13:0] a);
    return {2'b10, a, 2'b01, ~a};
  endfunction

  // Synchronous ROM model
  always @(posedge clk) begin
    if (rom_rd) rom_data <= rom_word(rom_addr);
  end

  // Scoreboard: data pushed at a grant is checked in the following cycle
  always @(posedge clk) begin
    int n;
    logic [31:0] e;
    n = pend_cnt;
    pend_cnt = 0;
    #2;
    repeat (n) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: queue empty at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (memcode_data !== e) begin
          errors++;
          $display("FAIL memcode_data: got %h exp %h at %0t", memcode_data, e, $time);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [13:0] a);
    exp_q.push_back(rom_word(a));
    pend_cnt++;
  endtask

  task automatic clear_inputs();
    req_rd = '0; req_addr = '0; host_rd = 1'b0; host_addr = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_b = 1'b0;
    @(negedge clk);
    #2 rst_b = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rom_rd !== 1'b0 || rom_addr !== 14'd0) begin errors++;
      $display("FAIL reset_rom: got rd=%b addr=%h exp 0/0", rom_rd, rom_addr); end
    checks++; if (req_read_valid !== 4'b0 || host_ready !== 1'b0) begin errors++;
      $display("FAIL reset_grants: got %b/%b exp 0000/0", req_read_valid, host_ready); end
    checks++; if (host_rdata !== 32'd0 || host_rdata_valid !== 1'b0) begin errors++;
      $display("FAIL reset_host: got %h/%b exp 0/0", host_rdata, host_rdata_valid); end
    checks++; if (dbg_last !== 2'd3 || dbg_streak !== 3'd0) begin errors++;
      $display("FAIL reset_state: got last=%0d streak=%0d exp 3/0", dbg_last, dbg_streak); end
    #2 rst_b = 1'b1;
  endtask

  task automatic test_idle(input logic [1:0] exp_last);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      clear_inputs();
      @(negedge clk);
      checks++;
      if (rom_rd !== 1'b0 || rom_addr !== 14'd0 || req_read_valid !== 4'b0 || host_ready !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs: got rd=%b addr=%h gnt=%b hr=%b exp 0", rom_rd, rom_addr, req_read_valid, host_ready);
      end
      checks++;
      if (dbg_last !== exp_last) begin
        errors++;
        $display("FAIL idle_last_grant: got %0d exp %0d", dbg_last, exp_last);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [13:0] a[NR];
    int k;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      for (int r = 0; r < NR; r++) begin
        a[r] = 14'($urandom_range(0, 16383));
        req_addr[14*r +: 14] = a[r];
      end
      req_rd = 4'b1111;
      k = c % NR;
      @(negedge clk);
      checks++;
      if (req_read_valid !== 4'(1 << k) || host_ready !== 1'b0) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %b exp %b", c, req_read_valid, 4'(1 << k));
      end
      checks++;
      if (rom_rd !== 1'b1 || rom_addr !== a[k]) begin
        errors++;
        $display("FAIL rr_addr[%0d]: got %b/%h exp 1/%h", c, rom_rd, rom_addr, a[k]);
      end
      push_exp(a[k]);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_alternate();
    int seq[3] = '{1, 3, 1};
    logic [13:0] a;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      a = 14'($urandom_range(0, 16383));
      req_addr[14*1 +: 14] = a;
      req_addr[14*3 +: 14] = ~a;
      req_rd = 4'b1010;
      @(negedge clk);
      checks++;
      if (req_read_valid !== 4'(1 << seq[c])) begin
        errors++;
        $display("FAIL alt_grant[%0d]: got %b exp %b", c, req_read_valid, 4'(1 << seq[c]));
      end
      push_exp((seq[c] == 1) ? a : ~a);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_host_priority();
    logic [13:0] ha;
    logic [13:0] ra;
    next_cycle();
    clear_inputs();
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      ha = 14'($urandom_range(0, 16383));
      ra = 14'($urandom_range(0, 16383));
      host_rd = 1'b1; host_addr = ha;
      req_addr[14*2 +: 14] = ra;
      req_rd = (c < 5) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      checks++;
      if (c == 4) begin
        if (host_ready !== 1'b0 || req_read_valid !== 4'b0100 || rom_addr !== ra) begin
          errors++;
          $display("FAIL hp_req_turn: got hr=%b gnt=%b addr=%h exp 0/0100/%h", host_ready, req_read_valid, rom_addr, ra);
        end
        push_exp(ra);
      end else begin
        if (host_ready !== 1'b1 || req_read_valid !== 4'b0 || rom_addr !== ha) begin
          errors++;
          $display("FAIL hp_host[%0d]: got hr=%b gnt=%b addr=%h exp 1/0000/%h", c, host_ready, req_read_valid, rom_addr, ha);
        end
        push_exp(ha);
      end
      checks++;
      if (dbg_streak !== ((c < 5) ? 3'(c) : 3'd0)) begin
        errors++;
        $display("FAIL hp_streak[%0d]: got %0d exp %0d", c, dbg_streak, (c < 5) ? c : 0);
      end
    end
    next_cycle();
    clear_inputs();
    repeat (2) next_cycle();
  endtask

  task automatic test_host_read();
    next_cycle();
    host_rd = 1'b1; host_addr = 14'h0123;
    @(negedge clk);
    checks++;
    if (host_ready !== 1'b1 || rom_addr !== 14'h0123 || host_rdata_valid !== 1'b0) begin
      errors++;
      $display("FAIL hr_grant: got hr=%b addr=%h v=%b exp 1/0123/0", host_ready, rom_addr, host_rdata_valid);
    end
    push_exp(14'h0123);
    next_cycle();
    host_rd = 1'b0;
    @(negedge clk);
    checks++;
    if (host_rdata_valid !== 1'b0) begin
      errors++; $display("FAIL hr_valid_t1: got %b exp 0", host_rdata_valid);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (host_rdata_valid !== 1'b1 || host_rdata !== rom_word(14'h0123)) begin
      errors++;
      $display("FAIL hr_data_t2: got %b/%h exp 1/%h", host_rdata_valid, host_rdata, rom_word(14'h0123));
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (host_rdata_valid !== 1'b0 || host_rdata !== rom_word(14'h0123)) begin
      errors++;
      $display("FAIL hr_hold_t3: got %b/%h exp 0/%h", host_rdata_valid, host_rdata, rom_word(14'h0123));
    end
  endtask

  task automatic test_host_saturated();
    logic [13:0] ha;
    next_cycle();
    clear_inputs();
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      ha = 14'($urandom_range(0, 16383));
      host_rd = 1'b1; host_addr = ha;
      req_rd = (c < 4) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      checks++;
      if (host_ready !== 1'b1 || req_read_valid !== 4'b0 || rom_addr !== ha) begin
        errors++;
        $display("FAIL sat_host[%0d]: got hr=%b gnt=%b addr=%h exp 1/0000/%h", c, host_ready, req_read_valid, rom_addr, ha);
      end
      push_exp(ha);
    end
    checks++;
    if (dbg_streak !== 3'(HM)) begin
      errors++; $display("FAIL sat_streak: got %0d exp %0d", dbg_streak, HM);
    end
    next_cycle();
    clear_inputs();
    repeat (2) next_cycle();
  endtask

  task automatic test_drop();
    logic [13:0] ra;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      host_rd = 1'b1; host_addr = 14'h0055;
      req_rd = 4'b0010;
      @(negedge clk);
      checks++;
      if (host_ready !== 1'b1 || req_read_valid !== 4'b0) begin
        errors++; $display("FAIL drop_hold[%0d]: got hr=%b gnt=%b exp 1/0000", c, host_ready, req_read_valid);
      end
      push_exp(14'h0055);
    end
    next_cycle();
    ra = 14'($urandom_range(0, 16383));
    host_rd = 1'b0; req_rd = 4'b0100; req_addr[14*2 +: 14] = ra;
    @(negedge clk);
    checks++;
    if (req_read_valid !== 4'b0100 || rom_addr !== ra) begin
      errors++; $display("FAIL drop_next: got %b/%h exp 0100/%h", req_read_valid, rom_addr, ra);
    end
    push_exp(ra);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (dbg_last !== 2'd2) begin
      errors++; $display("FAIL drop_last: got %0d exp 2", dbg_last);
    end
    repeat (2) next_cycle();
  endtask

  task automatic test_reset_mid();
    next_cycle();
    host_rd = 1'b1; host_addr = 14'h2A5A;
    @(negedge clk);
    checks++;
    if (host_ready !== 1'b1) begin
      errors++; $display("FAIL rm_grant: got %b exp 1", host_ready);
    end
    push_exp(14'h2A5A);
    next_cycle();
    host_rd = 1'b0;
    rst_b = 1'b0;
    next_cycle();
    rst_b = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (host_rdata_valid !== 1'b0 || host_rdata !== 32'd0) begin
        errors++;
        $display("FAIL rm_no_pulse[%0d]: got %b/%h exp 0/0", c, host_rdata_valid, host_rdata);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  m_last;
    logic [2:0]  m_streak;
    logic [3:0]  rq;
    logic        hrd;
    logic [13:0] a[NR];
    logic [13:0] ha;
    logic        any, hg, rg, found;
    logic [1:0]  w;
    logic [3:0]  egnt;
    logic [13:0] eaddr;
    logic        g1, g2;
    logic [13:0] a1, a2;
    int          idx;
    do_reset();
    m_last = 2'd3; m_streak = 3'd0;
    g1 = 1'b0; g2 = 1'b0; a1 = '0; a2 = '0;
    for (int c = 0; c < 300; c++) begin
      next_cycle();
      rq  = 4'($urandom_range(0, 15));
      hrd = ($urandom_range(0, 2) != 0);
      ha  = 14'($urandom_range(0, 16383));
      for (int r = 0; r < NR; r++) begin
        a[r] = 14'($urandom_range(0, 16383));
        req_addr[14*r +: 14] = a[r];
      end
      req_rd = rq; host_rd = hrd; host_addr = ha;
      any = |rq;
      hg  = hrd && !((m_streak == 3'(HM)) && any);
      found = 1'b0; w = '0;
      for (int i = 1; i <= NR; i++) begin
        idx = (int'(m_last) + i) % NR;
        if (!found && rq[idx]) begin found = 1'b1; w = 2'(idx); end
      end
      rg = found && !hg;
      egnt  = rg ? 4'(1 << w) : 4'b0;
      eaddr = hg ? ha : (rg ? a[w] : 14'd0);
      @(negedge clk);
      checks++;
      if (host_ready !== hg || req_read_valid !== egnt || rom_rd !== (hg || rg) || rom_addr !== eaddr) begin
        errors++;
        $display("FAIL b2b_grant[%0d]: got hr=%b gnt=%b rd=%b addr=%h exp %b/%b/%b/%h",
                 c, host_ready, req_read_valid, rom_rd, rom_addr, hg, egnt, hg || rg, eaddr);
      end
      checks++;
      if (host_rdata_valid !== g2 || (g2 && host_rdata !== rom_word(a2))) begin
        errors++;
        $display("FAIL b2b_host_rdata[%0d]: got %b/%h exp %b/%h", c, host_rdata_valid, host_rdata, g2, rom_word(a2));
      end
      if (hg || rg) push_exp(eaddr);
      g2 = g1; a2 = a1; g1 = hg; a1 = ha;
      if (rg) m_last = w;
      if (!any || rg) m_streak = 3'd0;
      else if (hg && m_streak != 3'(HM)) m_streak = m_streak + 3'd1;
    end
    next_cycle();
    clear_inputs();
    repeat (3) next_cycle();
  endtask

  initial begin
    clear_inputs();
    rst_b = 1'b0;
    test_reset();
    test_idle(2'd3);
    test_round_robin();
    test_idle(2'd3);
    test_alternate();
    test_host_priority();
    test_host_read();
    test_host_saturated();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    repeat (2) next_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
